// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: state encoding, line levels
// and a helper that gives the frame length in clk cycles.
package uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Cycles from start bit to stop bit inclusive.
  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input logic par_en);
    return 32'd2 + data_width + {31'd0, par_en};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shifter for the UART transmitter: holds the latched word, presents
// the current LSB and counts payload bits so the FSM knows when to leave DATA.
module uart_tx_serializer #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [data_width-1:0] data,
  input  logic                  shift_en,
  input  logic                  cnt_clr,
  input  logic                  cnt_inc,
  output logic                  data_bit,
  output logic                  ser_done
);

  localparam int CW = $clog2(data_width);
  localparam logic [CW-1:0] LAST = CW'(data_width - 1);

  logic [data_width-1:0] shift;
  logic [CW-1:0]         cnt;

  // Shift register: load on acceptance, move right as each bit is emitted.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift <= '0;
    end else if (load) begin
      shift <= data;
    end else if (shift_en) begin
      shift <= shift >> 1;
    end
  end

  // Bit counter: cleared on entry to DATA, holds at the last index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc && !ser_done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign data_bit = shift[0];
  assign ser_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framing controller: accepts a word, exports it to the parity
// calculator, and emits start/data/parity/stop bits one per baud clock.
// tx_out and busy are registered from the next state, so the line changes on
// the same edge that the FSM changes state.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic [data_width-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_bit,
  output logic [data_width-1:0] frame_data,
  output logic                  tx_out,
  output logic                  busy
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   par_en_q;
  logic   tx_nxt;
  logic   data_bit;
  logic   ser_done;

  uart_tx_serializer #(
    .data_width(data_width)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .data     (p_data),
    .shift_en (state_nxt == ST_DATA),
    .cnt_clr  (state == ST_START),
    .cnt_inc  (state == ST_DATA),
    .data_bit (data_bit),
    .ser_done (ser_done)
  );

  // Next-state logic; new words are taken only in IDLE or STOP.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_valid) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (ser_done) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP: begin
        if (data_valid) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Line level for the state being entered.
  always_comb begin
    tx_nxt = IDLE_LEVEL;
    case (state_nxt)
      ST_START:  tx_nxt = START_BIT;
      ST_DATA:   tx_nxt = data_bit;
      ST_PARITY: tx_nxt = par_bit;
      ST_STOP:   tx_nxt = STOP_BIT;
      default:   tx_nxt = IDLE_LEVEL;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      tx_out <= IDLE_LEVEL;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_out <= tx_nxt;
      busy   <= (state_nxt != ST_IDLE);
    end
  end

  // Frame word and parity enable are captured only on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data <= '0;
      par_en_q   <= 1'b0;
    end else if (accept) begin
      frame_data <= p_data;
      par_en_q   <= par_en;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl. Each accepted word pushes its
// expected per-cycle {tx_out, busy, frame_data} onto a scoreboard queue; every
// falling edge pops one entry (or expects idle) and compares.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  typedef struct packed {
    logic          tx;
    logic          busy;
    logic [DW-1:0] fd;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          pb;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_valid = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          par_en = 1'b0;
  logic          par_bit = 1'b0;
  logic [DW-1:0] frame_data;
  logic          tx_out;
  logic          busy;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  exp_t          sb[$];
  logic [DW-1:0] model_fd = '0;
  vec_t          vecs[7];

  uart_tx_frame_ctrl #(
    .data_width(DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_valid (data_valid),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_bit    (par_bit),
    .frame_data (frame_data),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DW+1:0] act,
                       input logic [DW+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a word for acceptance on the next rising edge and queue its frame.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pb);
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_bit    = pb;
    model_fd   = d;
    sb.push_back('{tx: 1'b0, busy: 1'b1, fd: d});
    for (int i = 0; i < DW; i++) sb.push_back('{tx: d[i], busy: 1'b1, fd: d});
    if (pe) sb.push_back('{tx: pb, busy: 1'b1, fd: d});
    sb.push_back('{tx: 1'b1, busy: 1'b1, fd: d});
  endtask

  // Advance to the next falling edge and compare one expected cycle.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{tx: 1'b1, busy: 1'b0, fd: model_fd};
    check($sformatf("cycle %0d {tx,busy,frame_data}", cyc),
          {tx_out, busy, frame_data}, e);
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pb: 1'b0};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pb: 1'b1};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pb: 1'b0};
    vecs[3] = '{data: 8'h00, pe: 1'b1, pb: 1'b1};
    vecs[4] = '{data: 8'hFF, pe: 1'b0, pb: 1'b1};
    vecs[5] = '{data: 8'h3C, pe: 1'b1, pb: 1'b0};
    vecs[6] = '{data: 8'h81, pe: 1'b1, pb: 1'b1};

    // Reset state, then release.
    step();
    step();
    reset = 1'b0;
    step();

    // Table-driven frames; inputs are scrambled mid-frame and must not matter.
    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].pe, vecs[k].pb);
      step();
      data_valid = 1'b0;
      p_data     = ~vecs[k].data;
      par_en     = ~vecs[k].pe;
      drain();
      step();
    end

    // Back-to-back: valid held with 0x01, 0xFF presented during STOP.
    send(8'h01, 1'b0, 1'b0);
    repeat (10) step();
    send(8'hFF, 1'b0, 1'b0);
    step();
    data_valid = 1'b0;
    drain();
    step();

    // Ignored input: 0x55 pulsed during DATA of a 0x0F frame.
    send(8'h0F, 1'b0, 1'b0);
    step();
    data_valid = 1'b0;
    repeat (3) step();
    data_valid = 1'b1;
    p_data     = 8'h55;
    step();
    data_valid = 1'b0;
    drain();
    step();
    step();

    // Asynchronous reset during DATA bit 3.
    send(8'h96, 1'b0, 1'b0);
    step();
    data_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check("async reset tx_out", {{(DW+1){1'b0}}, tx_out}, {{(DW+1){1'b0}}, 1'b1});
    check("async reset busy", {{(DW+1){1'b0}}, busy}, '0);
    check("async reset frame_data", {2'b00, frame_data}, '0);
    sb.delete();
    model_fd = '0;
    step();
    step();
    reset = 1'b0;
    step();
    send(8'h3C, 1'b1, 1'b1);
    step();
    data_valid = 1'b0;
    drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
